// File: rtl/seq_gen.sv
// ---------------------------------------------------------------------------
// seq_gen
//   Serial pattern generator. When start is accepted in IDLE, it captures a
//   bit pattern with its length, repetition count and inter-frame gap. It then
//   shifts the pattern out MSB first, once per repetition. The requested
//   number of idle cycles separates consecutive frames. A single done pulse
//   follows the last bit of the last frame.
//
//   State | Meaning
//   ------+-----------------------------------------------------------------
//   IDLE  | waiting for start; outputs all low
//   SHIFT | driving pattern bit (len_reg - bitcnt) with valid=1
//   GAP   | idle spacing between repetitions, gap_reg cycles long
//   DONE  | one-cycle done pulse, then back to IDLE
//
// Parameters
//   PW : pattern register width (power of two, 2..16)
//   LW : length field width, log2(PW)
//
// Ports
//   clk     in   1   system clock, rising edge
//   rst     in   1   synchronous active-high reset
//   start   in   1   transmit request, accepted only in IDLE
//   pattern in   PW  bit pattern, captured on accepted start
//   len     in   LW  pattern length minus 1
//   reps    in   4   repetition count minus 1
//   gap     in   2   idle cycles between repetitions
//   x       out  1   serial data, 0 when valid=0
//   valid   out  1   x carries a pattern bit
//   busy    out  1   high in every state except IDLE
//   done    out  1   one-cycle pulse after the final bit
// ---------------------------------------------------------------------------
module seq_gen #(
    parameter int PW = 8,
    parameter int LW = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [PW-1:0] pattern,
    input  logic [LW-1:0] len,
    input  logic [3:0]    reps,
    input  logic [1:0]    gap,
    output logic          x,
    output logic          valid,
    output logic          busy,
    output logic          done
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_GAP   = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;

    logic [PW-1:0] r_pattern;
    logic [LW-1:0] r_len;
    logic [3:0]    r_reps;
    logic [1:0]    r_gap;
    logic [LW-1:0] r_bitcnt;
    logic [3:0]    r_repcnt;
    logic [1:0]    r_gapcnt;

    logic [PW-1:0] w_pattern_nxt;
    logic [LW-1:0] w_len_nxt;
    logic [3:0]    w_reps_nxt;
    logic [1:0]    w_gap_nxt;
    logic [LW-1:0] w_bitcnt_nxt;
    logic [3:0]    w_repcnt_nxt;
    logic [1:0]    w_gapcnt_nxt;

    logic [LW-1:0] w_bit_idx;
    logic          w_frame_end;
    logic          w_last_rep;

    // Counting bitcnt up and indexing from len_reg down sends MSB first.
    // The index stays within range because bitcnt never exceeds len_reg.
    assign w_bit_idx   = r_len - r_bitcnt;
    assign w_frame_end = (r_bitcnt == r_len);
    assign w_last_rep  = (r_repcnt == r_reps);

    // -----------------------------------------------------------------------
    // State and datapath registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_pattern <= '0;
            r_len     <= '0;
            r_reps    <= '0;
            r_gap     <= '0;
            r_bitcnt  <= '0;
            r_repcnt  <= '0;
            r_gapcnt  <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_pattern <= w_pattern_nxt;
            r_len     <= w_len_nxt;
            r_reps    <= w_reps_nxt;
            r_gap     <= w_gap_nxt;
            r_bitcnt  <= w_bitcnt_nxt;
            r_repcnt  <= w_repcnt_nxt;
            r_gapcnt  <= w_gapcnt_nxt;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state and datapath update
    // -----------------------------------------------------------------------
    always_comb begin
        w_state_nxt   = r_state;
        w_pattern_nxt = r_pattern;
        w_len_nxt     = r_len;
        w_reps_nxt    = r_reps;
        w_gap_nxt     = r_gap;
        w_bitcnt_nxt  = r_bitcnt;
        w_repcnt_nxt  = r_repcnt;
        w_gapcnt_nxt  = r_gapcnt;

        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_pattern_nxt = pattern;
                    w_len_nxt     = len;
                    w_reps_nxt    = reps;
                    w_gap_nxt     = gap;
                    w_bitcnt_nxt  = '0;
                    w_repcnt_nxt  = '0;
                    w_gapcnt_nxt  = '0;
                    w_state_nxt   = S_SHIFT;
                end
            end

            S_SHIFT: begin
                if (!w_frame_end) begin
                    w_bitcnt_nxt = r_bitcnt + LW'(1);
                end else if (w_last_rep) begin
                    w_state_nxt = S_DONE;
                end else if (r_gap == 2'd0) begin
                    // Next frame starts on the very next cycle, no bubble.
                    w_bitcnt_nxt = '0;
                    w_repcnt_nxt = r_repcnt + 4'd1;
                end else begin
                    // Down-counter reaches zero in the last GAP cycle.
                    w_gapcnt_nxt = r_gap - 2'd1;
                    w_state_nxt  = S_GAP;
                end
            end

            S_GAP: begin
                if (r_gapcnt == 2'd0) begin
                    w_bitcnt_nxt = '0;
                    w_repcnt_nxt = r_repcnt + 4'd1;
                    w_state_nxt  = S_SHIFT;
                end else begin
                    w_gapcnt_nxt = r_gapcnt - 2'd1;
                end
            end

            S_DONE: begin
                w_state_nxt = S_IDLE;
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Moore outputs: decoded from registers only
    // -----------------------------------------------------------------------
    always_comb begin
        valid = (r_state == S_SHIFT);
        busy  = (r_state != S_IDLE);
        done  = (r_state == S_DONE);
        x     = valid & r_pattern[w_bit_idx];
    end

endmodule

// File: tb/tb_seq_gen.sv
module tb_seq_gen;

    localparam int PW = 8;
    localparam int LW = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [PW-1:0] pattern = '0;
    logic [LW-1:0] len = '0;
    logic [3:0]    reps = '0;
    logic [1:0]    gap = '0;
    logic          x;
    logic          valid;
    logic          busy;
    logic          done;

    int total = 0;
    int bad   = 0;

    // Scoreboard entry per cycle: {busy, valid, x, done}
    logic [3:0] sb_q[$];

    typedef struct {
        logic [7:0] pat;
        logic [2:0] l;
        logic [3:0] r;
        logic [1:0] g;
        bit         d;
    } req_t;

    seq_gen #(.PW(PW), .LW(LW)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .pattern (pattern),
        .len     (len),
        .reps    (reps),
        .gap     (gap),
        .x       (x),
        .valid   (valid),
        .busy    (busy),
        .done    (done)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    // Reference model: expected per-cycle outputs for one request,
    // from the first bit cycle through the first idle cycle after done.
    function automatic void push_frame(input logic [7:0] pat, input logic [2:0] l,
                                       input logic [3:0] r, input logic [1:0] g);
        for (int f = 0; f <= int'(r); f++) begin
            for (int b = int'(l); b >= 0; b--)
                sb_q.push_back({1'b1, 1'b1, pat[b], 1'b0});
            if (f != int'(r))
                for (int k = 0; k < int'(g); k++)
                    sb_q.push_back(4'b1000);
        end
        sb_q.push_back(4'b1001);
        sb_q.push_back(4'b0000);
    endfunction

    function automatic int busy_expect(input logic [2:0] l, input logic [3:0] r,
                                       input logic [1:0] g);
        return (int'(r) + 1) * (int'(l) + 1) + int'(r) * int'(g) + 1;
    endfunction

    // Advance one cycle; optionally hammer start and scramble the inputs,
    // which the DUT must ignore while busy.
    task automatic adv(input bit d);
        @(posedge clk);
        #1;
        if (d) begin
            start   = 1'b1;
            pattern = PW'($urandom);
            len     = LW'($urandom);
            reps    = 4'($urandom);
            gap     = 2'($urandom);
        end else begin
            start = 1'b0;
        end
    endtask

    task automatic kick(input logic [7:0] pat, input logic [2:0] l,
                        input logic [3:0] r, input logic [1:0] g);
        pattern = pat;
        len     = l;
        reps    = r;
        gap     = g;
        start   = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic test_reset();
        logic [3:0] obs;
        rst     = 1'b1;
        start   = 1'b1;
        pattern = 8'hFF;
        len     = 3'd7;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            @(negedge clk);
            obs = {busy, valid, x, done};
            total++;
            if (obs !== 4'b0000) begin
                bad++;
                $display("FAIL reset_prio[%0d] {busy,valid,x,done} got=%b want=0000", i, obs);
            end
        end
        @(posedge clk);
        #1;
        rst   = 1'b0;
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            obs = {busy, valid, x, done};
            total++;
            if (obs !== 4'b0000) begin
                bad++;
                $display("FAIL reset_idle[%0d] {busy,valid,x,done} got=%b want=0000", i, obs);
            end
            adv(1'b0);
        end
    endtask

    task automatic test_frames();
        req_t       tbl[$];
        logic [3:0] exp, obs;
        int         nbusy, ncyc;
        tbl.push_back('{8'h05, 3'd2, 4'd0,  2'd0, 1'b0});
        tbl.push_back('{8'hA5, 3'd7, 4'd2,  2'd3, 1'b0});
        tbl.push_back('{8'hB3, 3'd0, 4'd15, 2'd0, 1'b0});
        tbl.push_back('{8'h81, 3'd7, 4'd0,  2'd1, 1'b1});
        tbl.push_back('{8'h6E, 3'd4, 4'd1,  2'd1, 1'b1});
        for (int i = 0; i < 4; i++)
            tbl.push_back('{8'($urandom), 3'($urandom), 4'($urandom_range(0, 3)),
                            2'($urandom), 1'b1});
        foreach (tbl[t]) begin
            nbusy = 0;
            ncyc  = 0;
            push_frame(tbl[t].pat, tbl[t].l, tbl[t].r, tbl[t].g);
            kick(tbl[t].pat, tbl[t].l, tbl[t].r, tbl[t].g);
            while (sb_q.size() > 0) begin
                @(negedge clk);
                exp = sb_q.pop_front();
                obs = {busy, valid, x, done};
                if (busy) nbusy++;
                total++;
                if (obs !== exp) begin
                    bad++;
                    $display("FAIL frames[%0d] cyc=%0d {busy,valid,x,done} got=%b want=%b",
                             t, ncyc, obs, exp);
                end
                ncyc++;
                adv(tbl[t].d && sb_q.size() >= 2);
            end
            total++;
            if (nbusy != busy_expect(tbl[t].l, tbl[t].r, tbl[t].g)) begin
                bad++;
                $display("FAIL frames_busy[%0d] got=%0d want=%0d", t, nbusy,
                         busy_expect(tbl[t].l, tbl[t].r, tbl[t].g));
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] exp, obs;
        logic [2:0] hist;
        int         nvalid, ndet, ndone, ncyc;
        hist   = '0;
        nvalid = 0;
        ndet   = 0;
        ndone  = 0;
        ncyc   = 0;
        push_frame(8'h05, 3'd2, 4'd1, 2'd0);
        kick(8'h05, 3'd2, 4'd1, 2'd0);
        while (sb_q.size() > 0) begin
            @(negedge clk);
            exp = sb_q.pop_front();
            obs = {busy, valid, x, done};
            if (valid) begin
                hist = {hist[1:0], x};
                nvalid++;
                if (nvalid >= 3 && hist == 3'b101) ndet++;
            end
            if (done) ndone++;
            total++;
            if (obs !== exp) begin
                bad++;
                $display("FAIL b2b cyc=%0d {busy,valid,x,done} got=%b want=%b", ncyc, obs, exp);
            end
            ncyc++;
            adv(1'b0);
        end
        total++;
        if (ndet < 2) begin
            bad++;
            $display("FAIL b2b_detect got=%0d want>=2", ndet);
        end
        total++;
        if (nvalid != 6 || ndone != 1) begin
            bad++;
            $display("FAIL b2b_counts valid=%0d done=%0d want valid=6 done=1", nvalid, ndone);
        end
    endtask

    task automatic test_ignore_start();
        logic [3:0] exp, obs;
        int         ndone, ncyc;
        ndone = 0;
        ncyc  = 0;
        push_frame(8'h3C, 3'd7, 4'd1, 2'd2);
        kick(8'h3C, 3'd7, 4'd1, 2'd2);
        while (sb_q.size() > 0) begin
            @(negedge clk);
            exp = sb_q.pop_front();
            obs = {busy, valid, x, done};
            if (done) ndone++;
            total++;
            if (obs !== exp) begin
                bad++;
                $display("FAIL ignore_start cyc=%0d {busy,valid,x,done} got=%b want=%b",
                         ncyc, obs, exp);
            end
            ncyc++;
            adv(sb_q.size() >= 2);
        end
        total++;
        if (ndone != 1) begin
            bad++;
            $display("FAIL ignore_start_done got=%0d want=1", ndone);
        end
    endtask

    task automatic test_reset_mid();
        logic [3:0] exp, obs;
        int         ncyc;
        push_frame(8'h96, 3'd7, 4'd0, 2'd0);
        kick(8'h96, 3'd7, 4'd0, 2'd0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            exp = sb_q.pop_front();
            obs = {busy, valid, x, done};
            total++;
            if (obs !== exp) begin
                bad++;
                $display("FAIL rst_mid_pre[%0d] {busy,valid,x,done} got=%b want=%b", i, obs, exp);
            end
            if (i < 3) adv(1'b0);
            if (i == 2) rst = 1'b1;
        end
        sb_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        sb_q.push_back(4'b0000);
        push_frame(8'h5A, 3'd7, 4'd1, 2'd1);
        pattern = 8'h5A;
        len     = 3'd7;
        reps    = 4'd1;
        gap     = 2'd1;
        start   = 1'b1;
        ncyc    = 0;
        while (sb_q.size() > 0) begin
            @(negedge clk);
            exp = sb_q.pop_front();
            obs = {busy, valid, x, done};
            total++;
            if (obs !== exp) begin
                bad++;
                $display("FAIL rst_mid_post cyc=%0d {busy,valid,x,done} got=%b want=%b",
                         ncyc, obs, exp);
            end
            ncyc++;
            adv(1'b0);
        end
    endtask

    initial begin
        @(posedge clk);
        #1;
        test_reset();
        test_frames();
        test_back_to_back();
        test_ignore_start();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/seq_gen.md
SEQ_GEN -- requirements
Module: seq_gen

Interface
REQ-001 Parameter PW, default 8, pattern register width; legal values are powers of two, 2 to 16.
REQ-002 Parameter LW, default 3, length field width, equal to log2(PW).
REQ-003 clk  input  1  system clock; all state changes on the rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 start  input  1  request to transmit, sampled on the rising edge.
REQ-006 pattern  input  PW  bit pattern to transmit, captured when start is accepted.
REQ-007 len  input  LW  pattern length minus 1: bits pattern[len] down to pattern[0] are sent.
REQ-008 reps  input  4  repetition count minus 1: the frame is sent reps+1 times.
REQ-009 gap  input  2  number of idle cycles between repetitions (0..3).
REQ-010 x  output  1  serial bit stream, MSB first; 0 whenever valid=0.
REQ-011 valid  output  1  x carries a pattern bit this cycle.
REQ-012 busy  output  1  high in every state except IDLE.
REQ-013 done  output  1  one-cycle pulse after the final bit of the final repetition.

Function
REQ-014 The block shall be a Moore FSM with states IDLE, SHIFT, GAP, DONE; all outputs shall be decoded from registered state and datapath registers only, with no combinational input-to-output path.
REQ-015 IDLE: start=1 shall capture pattern, len, reps, gap into internal registers, clear the bit and repetition counters, and transition to SHIFT; start=0 keeps IDLE.
REQ-016 Latency: start sampled at edge k shall give valid=1 and x=pattern[len] in the cycle after edge k.
REQ-017 SHIFT: valid=1, x=captured pattern bit at index (len_reg - bitcnt); bitcnt increments each cycle.
REQ-018 SHIFT end of frame (bitcnt==len_reg): if repcnt==reps_reg go to DONE; else if gap_reg==0 go to SHIFT with bitcnt=0 and repcnt+1 (back-to-back frames, no bubble); else go to GAP.
REQ-019 GAP: valid=0, x=0, busy=1 for exactly gap_reg cycles, then SHIFT with bitcnt=0 and repcnt+1.
REQ-020 DONE: done=1, busy=1, valid=0, x=0 for one cycle, then IDLE unconditionally.
REQ-021 start shall be ignored in SHIFT, GAP and DONE; captured registers shall not change until the next accepted start.
REQ-022 Changes to pattern/len/reps/gap inputs while busy=1 shall have no effect on the transmission in progress.
REQ-023 len=0 shall send one bit per frame; len=LW'(PW-1) shall send all PW bits; reps=15 shall send 16 frames.
REQ-024 Total busy cycles per request shall equal (reps+1)*(len+1) + reps*gap + 1.
REQ-025 Counters shall be sized so no wrap occurs within a legal request; repcnt shall be 4 bits and bitcnt LW bits.

Reset
REQ-026 rst=1 at a rising edge shall force IDLE and clear all counters and captured registers, regardless of state or start.
REQ-027 After reset: x=0, valid=0, busy=0, done=0.
REQ-028 rst asserted mid-frame shall abort the transmission without a done pulse; start in the first cycle after rst deasserts shall be accepted normally.
REQ-029 rst shall have priority over start on the same edge.

Verification
REQ-030 pattern=8'h05, len=2, reps=0, gap=0, start pulse -> x=1,0,1 with valid=1 for 3 cycles starting the cycle after start, then done=1 for one cycle, then busy=0.
REQ-031 pattern=8'h05, len=2, reps=1, gap=0 -> x=1,0,1,1,0,1 contiguous (valid 6 cycles), done once; feeding x into the team's 101 Moore detector gives two or more detections.
REQ-032 pattern=8'hA5, len=7, reps=2, gap=3 -> three frames 10100101, each separated by 3 cycles of valid=0, x=0; busy high 31 cycles.
REQ-033 len=0, pattern bit0=1, reps=15, gap=0 -> valid high 16 consecutive cycles, x=1 throughout, done after cycle 16.
REQ-034 start re-pulsed mid-frame with a different pattern -> output stream unchanged, single done.
REQ-035 rst=1 in the 4th bit of an 8-bit frame -> next cycle x=0, valid=0, busy=0, done never asserted; new start after release transmits a full frame.
